// File: rtl/uart_tx_arbiter.sv
// Shares one UART tx core between two byte-stream requesters, switching owner only at message boundaries.
// Latency: a request seen at a clock edge drives tx_start/ack from that edge on (seen at the next edge); one byte per tx_busy cycle.
// Backpressure: a requester holds req/data until its ack; the next byte waits for tx_busy to fall; an idle owner is released after HOLD_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int HOLD_TIMEOUT = 1_000_000,
  parameter int BUSY_GUARD   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       last0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  input  logic       last1,
  output logic       ack1,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       active
);

  localparam int HW = (HOLD_TIMEOUT > 2) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam int GW = (BUSY_GUARD > 2) ? $clog2(BUSY_GUARD) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TIMEOUT - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(BUSY_GUARD - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            owner;      // 0 = requester 0, 1 = requester 1
  logic            rr;         // round-robin pointer: who wins a tie
  logic            rr_mode;    // mode was round-robin when this message was granted
  logic            last_q;
  logic [7:0]      tx_data_q;
  logic [HW-1:0]   hold_cnt;
  logic [GW-1:0]   guard_cnt;

  logic            elig0;
  logic            elig1;
  logic            owner_req;
  logic            pick;
  logic            load;
  logic            release_msg;

  // mode only matters for the IDLE decision; an owner keeps its message regardless
  assign elig0     = req0 & ((mode == 2'b00) | mode[1]);
  assign elig1     = req1 & ((mode == 2'b01) | mode[1]);
  assign owner_req = owner ? req1 : req0;

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic, plus the byte-load and release strobes the datapath uses
  always_comb begin
    state_nxt   = state;
    pick        = owner;
    load        = 1'b0;
    release_msg = 1'b0;
    case (state)
      S_IDLE: begin
        if (elig0 || elig1) begin
          load      = 1'b1;
          pick      = (elig0 && elig1) ? rr : elig1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // a core that never raises busy must not stall the arbiter
        if (tx_busy || (guard_cnt == GUARD_LAST)) begin
          state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            release_msg = 1'b1;
            state_nxt   = S_IDLE;
          end else begin
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // a ready owner byte wins over a timeout landing in the same cycle
        if (owner_req) begin
          load      = 1'b1;
          state_nxt = S_ISSUE;
        end else if (hold_cnt == HOLD_LAST) begin
          release_msg = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // owner, byte/last capture, round-robin pointer and the two dwell counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner     <= 1'b0;
      rr        <= 1'b0;
      rr_mode   <= 1'b0;
      last_q    <= 1'b0;
      tx_data_q <= 8'h00;
      hold_cnt  <= '0;
      guard_cnt <= '0;
    end else begin
      if (load) begin
        owner     <= pick;
        tx_data_q <= pick ? data1 : data0;
        last_q    <= pick ? last1 : last0;
      end
      if (load && (state == S_IDLE)) begin
        rr_mode <= mode[1];
      end
      if (release_msg && rr_mode) begin
        rr <= ~owner;
      end
      // counters restart whenever their state is entered
      hold_cnt  <= (state == S_HOLD)      ? hold_cnt + 1'b1  : '0;
      guard_cnt <= (state == S_WAIT_BUSY) ? guard_cnt + 1'b1 : '0;
    end
  end

  // Moore outputs: start/ack are the single ISSUE cycle, grant follows the owner
  always_comb begin
    tx_start = (state == S_ISSUE);
    ack0     = (state == S_ISSUE) && !owner;
    ack1     = (state == S_ISSUE) && owner;
    active   = (state != S_IDLE);
    grant    = 2'b00;
    if (state != S_IDLE) begin
      grant = owner ? 2'b10 : 2'b01;
    end
    tx_data  = tx_data_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with queue-fed requesters and a simple tx core model.
// Latency: checks sample 1-3 time units after the rising edge.
// Backpressure: requester models hold each byte until acked; tx model holds busy for busy_len cycles.
module tb_uart_tx_arbiter;

  localparam int HOLD_TO = 16;
  localparam int GUARD   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       req0, last0, ack0;
  logic [7:0] data0;
  logic       req1, last1, ack1;
  logic [7:0] data1;
  logic       tx_start, tx_busy, active;
  logic [7:0] tx_data;
  logic [1:0] grant;

  int errors = 0;
  int checks = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] txlog[$];
  logic [1:0] grantlog[$];
  int         busy_cnt = 0;
  int         busy_len = 3;
  logic       busy_en  = 1'b1;
  int         ack0_cnt = 0;
  int         ack1_cnt = 0;

  uart_tx_arbiter #(.HOLD_TIMEOUT(HOLD_TO), .BUSY_GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .req0(req0), .data0(data0), .last0(last0), .ack0(ack0),
    .req1(req1), .data1(data1), .last1(last1), .ack1(ack1),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .active(active)
  );

  always #5 clk = ~clk;

  // requester 0: present queue head, pop on ack
  initial begin
    req0 = 1'b0; data0 = 8'h00; last0 = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (ack0 === 1'b1 && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        req0 = 1'b1; data0 = q0[0][7:0]; last0 = q0[0][8];
      end else begin
        req0 = 1'b0; data0 = 8'h00; last0 = 1'b0;
      end
    end
  end

  // requester 1: same behaviour on its own queue
  initial begin
    req1 = 1'b0; data1 = 8'h00; last1 = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (ack1 === 1'b1 && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        req1 = 1'b1; data1 = q1[0][7:0]; last1 = q1[0][8];
      end else begin
        req1 = 1'b0; data1 = 8'h00; last1 = 1'b0;
      end
    end
  end

  // tx core model and output monitor
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (ack0 === 1'b1) ack0_cnt++;
      if (ack1 === 1'b1) ack1_cnt++;
      if (tx_start === 1'b1) begin
        txlog.push_back(tx_data);
        grantlog.push_back(grant);
        if (busy_en) busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      tx_busy = (busy_cnt > 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // wait until at least n bytes have been started and the arbiter is idle
  task automatic wait_tx(input int n, input string tag);
    int c;
    c = 0;
    while ((txlog.size() < n || active !== 1'b0) && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(c < 400), 32'd1);
  endtask

  // from a negedge: move to one edge past the requester model raising req, then #1 after it
  task automatic to_issue();
    @(posedge clk); #3;
    chk("pre_issue_tx_start", 32'(tx_start), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst  = 1'b0;
    mode = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_ack", 32'({ack0, ack1}), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // mode 00: requester 0 served, requester 1 pending but ineligible
    ack0_cnt = 0; ack1_cnt = 0;
    q1.push_back({1'b1, 8'h55});
    q0.push_back({1'b1, 8'h41});
    to_issue();
    chk("t2_tx_start", 32'(tx_start), 32'd1);
    chk("t2_tx_data", 32'(tx_data), 32'h41);
    chk("t2_ack0", 32'(ack0), 32'd1);
    chk("t2_ack1", 32'(ack1), 32'd0);
    chk("t2_grant", 32'(grant), 32'b01);
    chk("t2_active", 32'(active), 32'd1);
    @(negedge clk);
    wait_tx(1, "t2_done");
    repeat (10) @(negedge clk);
    chk("t2_ack1_never", 32'(ack1_cnt), 32'd0);
    chk("t2_req1_pending", 32'(q1.size()), 32'd1);
    chk("t2_txcount", 32'(txlog.size()), 32'd1);
    q1.delete();
    repeat (2) @(negedge clk);

    // round-robin contention, two 3-byte messages
    mode = 2'b10;
    txlog.delete(); grantlog.delete();
    q0.push_back({1'b0, 8'h41}); q0.push_back({1'b0, 8'h42}); q0.push_back({1'b1, 8'h43});
    q1.push_back({1'b0, 8'h78}); q1.push_back({1'b0, 8'h79}); q1.push_back({1'b1, 8'h7A});
    to_issue();
    chk("t3_first_grant", 32'(grant), 32'b01);
    @(negedge clk);
    wait_tx(6, "t3_done");
    chk("t3_count", 32'(txlog.size()), 32'd6);
    if (txlog.size() == 6) begin
      chk("t3_b0", 32'(txlog[0]), 32'h41);
      chk("t3_b1", 32'(txlog[1]), 32'h42);
      chk("t3_b2", 32'(txlog[2]), 32'h43);
      chk("t3_b3", 32'(txlog[3]), 32'h78);
      chk("t3_b4", 32'(txlog[4]), 32'h79);
      chk("t3_b5", 32'(txlog[5]), 32'h7A);
      chk("t3_g2", 32'(grantlog[2]), 32'b01);
      chk("t3_g3", 32'(grantlog[3]), 32'b10);
    end

    // tx_busy never rises: guard expires after 4 WAIT_BUSY cycles
    busy_en = 1'b0;
    mode = 2'b00;
    q0.push_back({1'b1, 8'h5A});
    to_issue();
    chk("t4_tx_start", 32'(tx_start), 32'd1);
    repeat (5) @(posedge clk); #1;
    chk("t4_still_active", 32'(active), 32'd1);
    @(posedge clk); #1;
    chk("t4_released", 32'(active), 32'd0);
    @(negedge clk);
    busy_en = 1'b1;
    repeat (2) @(negedge clk);

    // hold timeout: owner drops req after a non-final byte
    mode = 2'b10;
    q0.push_back({1'b0, 8'h11});
    to_issue();
    chk("t5_grant0", 32'(grant), 32'b01);
    q1.push_back({1'b1, 8'h22});
    repeat (19) @(posedge clk); #1;
    chk("t5_hold_active", 32'(active), 32'd1);
    chk("t5_hold_grant", 32'(grant), 32'b01);
    @(posedge clk); #1;
    chk("t5_release", 32'(active), 32'd0);
    @(posedge clk); #1;
    chk("t5_grant1", 32'(grant), 32'b10);
    chk("t5_tx_data", 32'(tx_data), 32'h22);
    chk("t5_ack1", 32'(ack1), 32'd1);
    @(negedge clk);
    wait_tx(1, "t5_done");
    repeat (2) @(negedge clk);

    // mode switched to 00 mid-message of requester 1
    txlog.delete(); grantlog.delete();
    ack1_cnt = 0;
    q1.push_back({1'b0, 8'h61}); q1.push_back({1'b0, 8'h62}); q1.push_back({1'b1, 8'h63});
    to_issue();
    chk("t6_grant1", 32'(grant), 32'b10);
    mode = 2'b00;
    q0.push_back({1'b1, 8'h30});
    @(negedge clk);
    wait_tx(4, "t6_msg_done");
    if (txlog.size() == 4) begin
      chk("t6_b2", 32'(txlog[2]), 32'h63);
      chk("t6_b3", 32'(txlog[3]), 32'h30);
      chk("t6_g3", 32'(grantlog[3]), 32'b01);
    end else begin
      chk("t6_count", 32'(txlog.size()), 32'd4);
    end
    q1.push_back({1'b1, 8'h77});
    q0.push_back({1'b1, 8'h31});
    repeat (2) @(negedge clk);
    wait_tx(5, "t6_req0_done");
    repeat (10) @(negedge clk);
    chk("t6_final_count", 32'(txlog.size()), 32'd5);
    chk("t6_ack1_count", 32'(ack1_cnt), 32'd3);
    chk("t6_req1_pending", 32'(q1.size()), 32'd1);
    q1.delete();
    repeat (2) @(negedge clk);

    // move the rr pointer to 1 so the reset check below means something
    mode = 2'b10;
    txlog.delete();
    q0.push_back({1'b1, 8'h01});
    @(negedge clk);
    wait_tx(1, "rr_setup_done");

    // reset in WAIT_DONE with grant=01
    mode = 2'b00;
    busy_len = 20;
    q0.push_back({1'b1, 8'h99});
    to_issue();
    repeat (3) @(posedge clk); #1;
    chk("t1_pre_grant", 32'(grant), 32'b01);
    chk("t1_pre_active", 32'(active), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    busy_cnt = 0;
    @(posedge clk); #1;
    chk("t1_tx_start", 32'(tx_start), 32'd0);
    chk("t1_ack", 32'({ack0, ack1}), 32'd0);
    chk("t1_grant", 32'(grant), 32'd0);
    chk("t1_active", 32'(active), 32'd0);
    chk("t1_tx_data", 32'(tx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    busy_len = 3;
    mode = 2'b10;
    q0.push_back({1'b1, 8'hA0});
    q1.push_back({1'b1, 8'hB0});
    to_issue();
    chk("t1_rr_reset", 32'(grant), 32'b01);
    @(negedge clk);
    txlog.delete();
    wait_tx(1, "t1_tail_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
